// File: rtl/tic_tac_toe.sv
// ---------------------------------------------------------------------------
// tic_tac_toe : two-player 3x3 tic-tac-toe game core.
//
// Sits between nine asynchronous cell push-buttons and the tri-colour cell
// LEDs / status flags. Each button is synchronized and edge-detected; a
// press on an empty cell while the game is active places the current
// player's mark and passes the turn. Wins and a full grid end the game
// until reset.
//
// Ports
//   clk               in   system clock, rising edge
//   reset             in   asynchronous active-high game clear
//   a..i              in   cell buttons, row-major a b c / d e f / g h i
//   p1_turn/p2_turn   out  player to move (both 0 once the game is over)
//   p1_win/p2_win     out  player owns a complete line
//   grid_full         out  all nine cells occupied
//   a_led..i_led      out  [0] player 1 owns, [1] player 2 owns,
//                          [2] cell lies on the winning line(s)
// ---------------------------------------------------------------------------
module tic_tac_toe (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       h,
  input  logic       i,
  output logic       p1_turn,
  output logic       p2_turn,
  output logic       p1_win,
  output logic       p2_win,
  output logic       grid_full,
  output logic [2:0] a_led,
  output logic [2:0] b_led,
  output logic [2:0] c_led,
  output logic [2:0] d_led,
  output logic [2:0] e_led,
  output logic [2:0] f_led,
  output logic [2:0] g_led,
  output logic [2:0] h_led,
  output logic [2:0] i_led
);

  // Cell k of every 9-bit vector: bit 0 = a ... bit 8 = i.
  logic [8:0] btn_s;
  logic [8:0] sync1_q;
  logic [8:0] sync2_q;
  logic [8:0] prev_q;
  logic [8:0] rise_s;
  logic [8:0] sel_s;

  logic [8:0] p1_q;
  logic [8:0] p1_d;
  logic [8:0] p2_q;
  logic [8:0] p2_d;
  logic       turn_q;   // 0 = player 1 to move, 1 = player 2
  logic       turn_d;

  logic       p1_win_s;
  logic       p2_win_s;
  logic       full_s;
  logic       active_s;
  logic       place_s;
  logic [8:0] line_s;
  logic [8:0] win_cells_s;

  // Cell mask of line k: rows 0-2, columns 3-5, diagonals 6-7.
  function automatic logic [8:0] line_mask(input logic [2:0] k);
    logic [8:0] m;
    case (k)
      3'd0:    m = 9'b000_000_111;
      3'd1:    m = 9'b000_111_000;
      3'd2:    m = 9'b111_000_000;
      3'd3:    m = 9'b001_001_001;
      3'd4:    m = 9'b010_010_010;
      3'd5:    m = 9'b100_100_100;
      3'd6:    m = 9'b100_010_001;
      3'd7:    m = 9'b001_010_100;
      default: m = 9'b000_000_000;
    endcase
    return m;
  endfunction

  assign btn_s = {i, h, g, f, e, d, c, b, a};

  // Button synchronizers and previous-sample flops. Resetting them to 1
  // makes a button that is held through reset release look already seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 9'h1FF;
      sync2_q <= 9'h1FF;
      prev_q  <= 9'h1FF;
    end else begin
      sync1_q <= btn_s;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_s = sync2_q & ~prev_q;
  // Isolate the lowest set bit: cell a has the highest priority.
  assign sel_s  = rise_s & (~rise_s + 9'd1);

  // Line evaluation; only one player can ever complete a line because
  // play stops at the first win.
  always_comb begin
    p1_win_s    = 1'b0;
    p2_win_s    = 1'b0;
    win_cells_s = 9'd0;
    line_s      = 9'd0;
    for (int k = 0; k < 8; k++) begin
      line_s = line_mask(3'(k));
      if ((p1_q & line_s) == line_s) begin
        p1_win_s    = 1'b1;
        win_cells_s = win_cells_s | line_s;
      end else if ((p2_q & line_s) == line_s) begin
        p2_win_s    = 1'b1;
        win_cells_s = win_cells_s | line_s;
      end else begin
        win_cells_s = win_cells_s;
      end
    end
  end

  assign full_s   = &(p1_q | p2_q);
  assign active_s = ~(p1_win_s | p2_win_s | full_s);
  assign place_s  = active_s && (sel_s != 9'd0) && ((sel_s & (p1_q | p2_q)) == 9'd0);

  // Next board/turn: the selected edge lands only on an empty cell.
  always_comb begin
    p1_d   = p1_q;
    p2_d   = p2_q;
    turn_d = turn_q;
    if (place_s) begin
      if (turn_q == 1'b0) begin
        p1_d = p1_q | sel_s;
      end else begin
        p2_d = p2_q | sel_s;
      end
      turn_d = ~turn_q;
    end else begin
      turn_d = turn_q;
    end
  end

  // Board and turn registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_q   <= 9'd0;
      p2_q   <= 9'd0;
      turn_q <= 1'b0;
    end else begin
      p1_q   <= p1_d;
      p2_q   <= p2_d;
      turn_q <= turn_d;
    end
  end

  assign p1_turn   = active_s & ~turn_q;
  assign p2_turn   = active_s & turn_q;
  assign p1_win    = p1_win_s;
  assign p2_win    = p2_win_s;
  assign grid_full = full_s;

  assign a_led = {win_cells_s[0], p2_q[0], p1_q[0]};
  assign b_led = {win_cells_s[1], p2_q[1], p1_q[1]};
  assign c_led = {win_cells_s[2], p2_q[2], p1_q[2]};
  assign d_led = {win_cells_s[3], p2_q[3], p1_q[3]};
  assign e_led = {win_cells_s[4], p2_q[4], p1_q[4]};
  assign f_led = {win_cells_s[5], p2_q[5], p1_q[5]};
  assign g_led = {win_cells_s[6], p2_q[6], p1_q[6]};
  assign h_led = {win_cells_s[7], p2_q[7], p1_q[7]};
  assign i_led = {win_cells_s[8], p2_q[8], p1_q[8]};

endmodule

// File: tb/tb_tic_tac_toe.sv
// ---------------------------------------------------------------------------
// tb_tic_tac_toe : scoreboard bench for tic_tac_toe. Each press pushes the
// expected board before and after its latency into a queue; a negedge
// monitor pops entries on their due cycle and compares.
// ---------------------------------------------------------------------------
module tb_tic_tac_toe;

  logic clk = 1'b0;
  logic reset;
  logic a, b, c, d, e, f, g, h, i;
  logic p1_turn, p2_turn, p1_win, p2_win, grid_full;
  logic [2:0] a_led, b_led, c_led, d_led, e_led, f_led, g_led, h_led, i_led;

  tic_tac_toe dut (
    .clk(clk), .reset(reset),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .i(i),
    .p1_turn(p1_turn), .p2_turn(p2_turn), .p1_win(p1_win), .p2_win(p2_win),
    .grid_full(grid_full),
    .a_led(a_led), .b_led(b_led), .c_led(c_led), .d_led(d_led), .e_led(e_led),
    .f_led(f_led), .g_led(g_led), .h_led(h_led), .i_led(i_led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          due;
    logic [26:0] leds;
    logic [4:0]  flags;
    string       tag;
  } exp_t;

  exp_t sb[$];

  // Reference model: owner per cell (0 empty, 1 P1, 2 P2) and mover.
  int own[9];
  int m_turn;

  wire [26:0] leds_w  = {i_led, h_led, g_led, f_led, e_led, d_led, c_led, b_led, a_led};
  wire [4:0]  flags_w = {p1_turn, p2_turn, p1_win, p2_win, grid_full};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int line_owner(input int c0, input int c1, input int c2);
    if (own[c0] != 0 && own[c0] == own[c1] && own[c1] == own[c2]) return own[c0];
    return 0;
  endfunction

  task automatic mark(input int c0, input int c1, input int c2,
                      inout int winner, inout logic [8:0] wc);
    int w;
    w = line_owner(c0, c1, c2);
    if (w != 0) begin
      winner = w;
      wc[c0] = 1'b1; wc[c1] = 1'b1; wc[c2] = 1'b1;
    end
  endtask

  task automatic model_expect(output logic [26:0] leds, output logic [4:0] flags);
    int winner;
    logic [8:0] wc;
    bit full, over;
    winner = 0;
    wc     = 9'd0;
    for (int r = 0; r < 3; r++) mark(3*r, 3*r+1, 3*r+2, winner, wc);
    for (int cc = 0; cc < 3; cc++) mark(cc, cc+3, cc+6, winner, wc);
    mark(0, 4, 8, winner, wc);
    mark(2, 4, 6, winner, wc);
    full = 1'b1;
    for (int k = 0; k < 9; k++) if (own[k] == 0) full = 1'b0;
    for (int k = 0; k < 9; k++)
      leds[3*k +: 3] = {wc[k], own[k] == 2, own[k] == 1};
    over  = (winner != 0) || full;
    flags = {!over && m_turn == 1, !over && m_turn == 2, winner == 1, winner == 2, full};
  endtask

  task automatic model_move(input logic [8:0] mask);
    logic [26:0] l;
    logic [4:0]  fl;
    model_expect(l, fl);
    if (fl[2] || fl[1] || fl[0]) return;
    for (int k = 0; k < 9; k++) begin
      if (mask[k]) begin
        if (own[k] == 0) begin
          own[k] = m_turn;
          m_turn = 3 - m_turn;
        end
        return;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 9; k++) own[k] = 0;
    m_turn = 1;
  endtask

  task automatic push(input int due, input string tag);
    exp_t x;
    model_expect(x.leds, x.flags);
    x.due = due;
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic set_btns(input logic [8:0] m);
    {i, h, g, f, e, d, c, b, a} = m;
  endtask

  // Raise the buttons in mask for hold cycles, then release for 10.
  task automatic press(input logic [8:0] mask, input int hold, input string tag);
    @(negedge clk);
    push(cyc + 2, {tag, "_pre"});
    model_move(mask);
    push(cyc + 3, {tag, "_post"});
    set_btns(mask);
    repeat (hold) @(negedge clk);
    set_btns(9'd0);
    repeat (10) @(negedge clk);
    push(cyc + 1, {tag, "_hold"});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_reset(input string tag);
    logic [26:0] l;
    logic [4:0]  fl;
    drain();
    #2 reset = 1'b1;
    model_reset();
    #1;
    model_expect(l, fl);
    check({tag, "_async_led"}, {5'd0, leds_w}, {5'd0, l});
    check({tag, "_async_flag"}, {27'd0, flags_w}, {27'd0, fl});
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push(cyc + 1, {tag, "_idle"});
    repeat (5) @(negedge clk);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t x;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      x = sb.pop_front();
      check({x.tag, "_led"}, {5'd0, leds_w}, {5'd0, x.leds});
      check({x.tag, "_flag"}, {27'd0, flags_w}, {27'd0, x.flags});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_btns(9'd0);
    model_reset();
    @(negedge clk);
    do_reset("rst0");

    // Sequential a..i: P1 wins on the a/c/e/g... diagonal c-e-g at g.
    for (int k = 0; k < 9; k++)
      press(9'b1 << k, 10, $sformatf("seq_%0d", k));

    // Re-press of an occupied cell, then a long hold on e.
    do_reset("rst1");
    press(9'b000_000_001, 10, "a_first");
    press(9'b000_000_001, 10, "a_again");
    press(9'b000_010_000, 50, "e_hold");

    // Draw: a b c e d f h g i.
    do_reset("rst2");
    begin
      int order[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
      for (int k = 0; k < 9; k++)
        press(9'b1 << order[k], 10, $sformatf("draw_%0d", k));
    end

    // Simultaneous b and d: only b lands.
    do_reset("rst3");
    press(9'b000_001_010, 10, "b_and_d");

    // Reset in mid-game with e held through release.
    do_reset("rst4");
    press(9'b000_000_001, 10, "mg_a");
    press(9'b000_000_010, 10, "mg_b");
    drain();
    set_btns(9'b000_010_000);
    repeat (4) @(negedge clk);
    do_reset("mid");
    push(cyc + 3, "held_e_1");
    push(cyc + 10, "held_e_2");
    repeat (12) @(negedge clk);
    set_btns(9'd0);
    repeat (5) @(negedge clk);
    press(9'b000_000_100, 10, "after_mid");

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
